// File: rtl/glip_channel_arbiter.sv
// rtl/glip_channel_arbiter.sv - round-robin arbiter/framer sharing one byte stream between byte sources
module glip_channel_arbiter #(
    parameter int CHANNELS = 4,
    parameter int MAXBURST = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CHANNELS*8-1:0] src_data,
    input  logic [CHANNELS-1:0]   src_valid,
    output logic [CHANNELS-1:0]   src_ready,
    input  logic [CHANNELS*5-1:0] src_avail,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CHANNELS-1:0]   grant,
    output logic                  busy
);

    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_DATA} state_t;

    localparam logic [4:0] MAXB = 5'(MAXBURST);

    state_t              state_q, state_d;
    logic [2:0]          rr_ptr_q, rr_ptr_d;
    logic [2:0]          chan_q, chan_d;
    logic [4:0]          len_q, len_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [CHANNELS-1:0] grant_q, grant_d;
    logic [7:0]          hdr_q, hdr_d;

    logic                found;
    logic [2:0]          pick;
    logic [4:0]          pick_avail;
    logic [4:0]          pick_len;
    logic [3:0]          len_m1;
    logic [7:0]          sel_data;
    logic                sel_valid;

    // Lowest rotated distance from rr_ptr+1 wins; constant indices keep the mux flat.
    always_comb begin
        int best_d;
        int d;
        best_d     = CHANNELS;
        d          = 0;
        pick       = '0;
        pick_avail = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            d = (i + CHANNELS - 1 - int'(rr_ptr_q)) % CHANNELS;
            if (src_avail[i*5 +: 5] != 5'd0 && d < best_d) begin
                best_d     = d;
                pick       = 3'(i);
                pick_avail = src_avail[i*5 +: 5];
            end
        end
        found    = (best_d < CHANNELS);
        pick_len = (pick_avail > MAXB) ? MAXB : pick_avail;
        len_m1   = 4'(pick_len - 5'd1);
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant_q[i]) begin
                sel_data = src_data[i*8 +: 8];
            end
        end
        sel_valid = |(src_valid & grant_q);
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        chan_d   = chan_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        hdr_d    = hdr_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    chan_d  = pick;
                    len_d   = pick_len;
                    grant_d = {{(CHANNELS-1){1'b0}}, 1'b1} << pick;
                    hdr_d   = {pick, 1'b0, len_m1};
                    state_d = S_HEADER;
                end
            end
            S_HEADER: begin
                if (out_ready) begin
                    cnt_d   = len_q;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (sel_valid && out_ready) begin
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_d  = S_IDLE;
                        rr_ptr_d = chan_q;
                        grant_d  = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= 3'(CHANNELS - 1);
            chan_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            grant_q  <= '0;
            hdr_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            chan_q   <= chan_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            hdr_q    <= hdr_d;
        end
    end

    // Header is registered; data phase passes the granted source straight through.
    always_comb begin
        out_valid = 1'b0;
        out_data  = 8'h00;
        src_ready = '0;
        case (state_q)
            S_HEADER: begin
                out_valid = 1'b1;
                out_data  = hdr_q;
            end
            S_DATA: begin
                out_valid = sel_valid;
                out_data  = sel_data;
                src_ready = grant_q & {CHANNELS{out_ready}};
            end
            default: ;
        endcase
    end

    assign grant = grant_q;
    assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_glip_channel_arbiter.sv
// tb/tb_glip_channel_arbiter.sv - directed self-checking bench for glip_channel_arbiter
module tb_glip_channel_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] src_data;
    logic [3:0]  src_valid;
    logic [3:0]  src_ready;
    logic [19:0] src_avail;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  grant;
    logic        busy;

    logic [4:0]  given [4];
    logic [4:0]  taken [4];
    logic        clear;
    logic [3:0]  valid_en;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          got [$];
    int          gcyc [$];
    int          exp_q [$];
    int          stall_bad = 0;
    logic        pend_v = 1'b0;
    logic [7:0]  pend_d = 8'h00;

    glip_channel_arbiter #(.CHANNELS(4), .MAXBURST(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_data  (src_data),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_avail (src_avail),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Source i emits 0x80 + 16*i + (bytes already taken); avail is its remaining fill.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            src_data[i*8 +: 8]  = 8'h80 + 8'(16 * i) + {3'b000, taken[i]};
            src_avail[i*5 +: 5] = given[i] - taken[i];
        end
    end
    assign src_valid = valid_en;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 4; i++) begin
            if (clear) taken[i] <= 5'd0;
            else if (src_valid[i] && src_ready[i]) taken[i] <= taken[i] + 5'd1;
        end
    end

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            got.push_back(int'(out_data));
            gcyc.push_back(cyc);
        end
        if (pend_v && out_valid && out_data != pend_d) stall_bad <= stall_bad + 1;
        pend_v <= out_valid && !out_ready;
        pend_d <= out_data;
    end

    task automatic check(input string tag, input int obs, input int expv);
        total++;
        if (obs != expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_run(input int start, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(start + k);
    endtask

    task automatic check_stream(input string tag, input int base);
        check({tag, "_len"}, got.size() - base, exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            if (base + k < got.size())
                check($sformatf("%s[%0d]", tag, k), got[base + k], exp_q[k]);
        end
        exp_q.delete();
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < max_cyc; n++) begin
            @(negedge clk);
            if (!busy && src_avail == 20'd0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({tag, "_timeout"}, 1, 0);
    endtask

    task automatic wait_taken(input string tag, input int ch, input int value);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            step();
            if (int'(taken[ch]) == value) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({tag, "_timeout"}, 1, 0);
    endtask

    task automatic reset_all();
        rst   = 1'b1;
        clear = 1'b1;
        for (int i = 0; i < 4; i++) given[i] = 5'd0;
        step();
        rst   = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        int base;
        int viol;
        bit ok;

        rst       = 1'b1;
        clear     = 1'b1;
        out_ready = 1'b0;
        valid_en  = 4'h0;
        for (int i = 0; i < 4; i++) given[i] = 5'd0;
        repeat (3) step();
        @(negedge clk);
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_src_ready", src_ready, 0);
        step();
        rst   = 1'b0;
        clear = 1'b0;

        // single burst, ch2 avail 3
        base      = got.size();
        valid_en  = 4'hF;
        out_ready = 1'b1;
        given[2]  = 5'd3;
        @(posedge clk);
        @(negedge clk);
        check("t1_grant", grant, 4'b0100);
        check("t1_header", out_data, 8'h42);
        check("t1_busy", busy, 1);
        wait_done("t1", 50);
        check("t1_grant_after", grant, 0);
        exp_q.push_back(8'h42);
        push_run(8'hA0, 3);
        check_stream("t1", base);

        // clamping, ch1 avail 24 -> 16 + 8
        step();
        base     = got.size();
        given[1] = 5'd24;
        wait_done("t2", 200);
        exp_q.push_back(8'h2F);
        push_run(8'h90, 16);
        exp_q.push_back(8'h27);
        push_run(8'hA0, 8);
        check_stream("t2", base);
        if (got.size() > base + 17) check("t2_idle_gap", gcyc[base + 17] - gcyc[base + 16], 2);

        // round robin from reset, ch0 re-requests during ch1 burst
        step();
        reset_all();
        base     = got.size();
        given[0] = 5'd2;
        given[1] = 5'd2;
        given[3] = 5'd2;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (grant == 4'b0010) begin
                ok = 1'b1;
                break;
            end
        end
        check("t3_grant_wait", ok, 1);
        step();
        given[0] = 5'd4;
        wait_done("t3", 100);
        exp_q.push_back(8'h01); push_run(8'h80, 2);
        exp_q.push_back(8'h21); push_run(8'h90, 2);
        exp_q.push_back(8'h61); push_run(8'hB0, 2);
        exp_q.push_back(8'h01); push_run(8'h82, 2);
        check_stream("t3", base);

        // out_ready toggling during a 5-byte ch2 burst
        step();
        base     = got.size();
        given[2] = 5'd5;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            step();
            out_ready = ~out_ready;
            if (!busy && src_avail == 20'd0) begin
                ok = 1'b1;
                break;
            end
        end
        check("t4a_done", ok, 1);
        out_ready = 1'b1;
        exp_q.push_back(8'h44);
        push_run(8'hA0, 5);
        check_stream("t4a", base);
        check("t4a_stall_stable", stall_bad, 0);

        // ch3 drops valid for 3 cycles mid-burst
        step();
        base     = got.size();
        given[3] = 5'd6;
        wait_taken("t4b", 3, 4);
        valid_en[3] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t4b_out_valid", out_valid, 0);
            check("t4b_grant", grant, 4'b1000);
            step();
        end
        valid_en[3] = 1'b1;
        wait_done("t4b", 50);
        exp_q.push_back(8'h63);
        push_run(8'hB2, 4);
        check_stream("t4b", base);

        // reset after 2 of 6 bytes
        step();
        reset_all();
        base     = got.size();
        given[0] = 5'd6;
        wait_taken("t5", 0, 2);
        rst       = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t5_rst_grant", grant, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_out_valid", out_valid, 0);
        check("t5_rst_out_data", out_data, 0);
        check("t5_rst_src_ready", src_ready, 0);
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t5_regrant", grant, 4'b0001);
        check("t5_header", out_data, 8'h03);
        wait_done("t5", 50);
        exp_q.push_back(8'h05); push_run(8'h80, 2);
        exp_q.push_back(8'h03); push_run(8'h82, 4);
        check_stream("t5", base);

        // idle for 100 cycles
        step();
        base = got.size();
        viol = 0;
        repeat (100) begin
            @(negedge clk);
            if (out_valid || busy || grant != 4'b0000) viol++;
        end
        check("t6_idle_viol", viol, 0);
        check_stream("t6", base);
        check("final_stall_stable", stall_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
